// File: rtl/dec_onehot_pkg.sv
// dec_onehot_pkg: shared state encoding, mode encodings and one-hot helper for the one-hot decoder/scanner
package dec_onehot_pkg;
  typedef enum logic [1:0] {S_IDLE, S_DIRECT, S_SCAN} state_e;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  function automatic logic [255:0] onehot(input int unsigned idx, input int unsigned width);
    return (idx < width) ? 256'(1) << idx : '0;
  endfunction
endpackage

// File: rtl/dec_onehot_scan_if.sv
// dec_onehot_scan_if: decoder bus (master drives en/mode/sel/valid/dwell; slave returns ready/arr/idx/wrap/err)
interface dec_onehot_scan_if #(
  parameter int SEL_W = 3,
  parameter int OUT_W = 8,
  parameter int DWELL_W = 4
) ();
  logic en_i;
  logic mode_i;
  logic [SEL_W-1:0] sel_i;
  logic valid_i;
  logic [DWELL_W-1:0] dwell_i;
  logic ready_o;
  logic [OUT_W-1:0] arr_o;
  logic [SEL_W-1:0] idx_o;
  logic wrap_o;
  logic err_o;
  modport master (
    output en_i, mode_i, sel_i, valid_i, dwell_i,
    input ready_o, arr_o, idx_o, wrap_o, err_o
  );
  modport slave (
    input en_i, mode_i, sel_i, valid_i, dwell_i,
    output ready_o, arr_o, idx_o, wrap_o, err_o
  );
endinterface

// File: rtl/dec_dwell_cnt.sv
// dec_dwell_cnt: dwell counter (clk, rst_n, clr_i, run_i, dwell_i in; tick_o when count reaches dwell_i)
module dec_dwell_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         run_i,
  input  logic [W-1:0] dwell_i,
  output logic         tick_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = run_i && cnt_q == dwell_i;
  always_comb cnt_d = clr_i ? '0 : !run_i ? cnt_q : tick_o ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dec_onehot_scan.sv
// dec_onehot_scan: registered binary-to-one-hot decoder with handshake, blanking and scan (clk, rst_n, bus slave)
module dec_onehot_scan
  import dec_onehot_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int OUT_W = 8,
  parameter int DWELL_W = 4
) (
  input logic clk,
  input logic rst_n,
  dec_onehot_scan_if.slave bus
);
  state_e state_q, state_d;
  logic ready, accept, in_range, entering, scan_run, tick, at_last, wrap_q, err_q, en_q;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] arr_q, arr_d;
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb state_d = (bus.mode_i == MODE_SCAN) ? S_SCAN : S_DIRECT;
  always_comb begin
    ready = state_q == S_DIRECT && bus.mode_i == MODE_DIRECT;
    entering = bus.mode_i == MODE_SCAN && state_q != S_SCAN;
    scan_run = bus.mode_i == MODE_SCAN && state_q == S_SCAN;
  end
  dec_dwell_cnt #(.W(DWELL_W)) u_dwell (
    .clk(clk),
    .rst_n(rst_n),
    .clr_i(entering),
    .run_i(scan_run),
    .dwell_i(bus.dwell_i),
    .tick_o(tick)
  );
  always_comb begin
    accept = bus.valid_i && ready;
    in_range = 32'(bus.sel_i) < OUT_W;
    at_last = idx_q == SEL_W'(OUT_W - 1);
    idx_d = (accept && in_range) ? bus.sel_i : tick ? (at_last ? '0 : idx_q + 1'b1) : idx_q;
    arr_d = !bus.en_i ? '0
          : accept ? (in_range ? OUT_W'(onehot(32'(bus.sel_i), OUT_W)) : '0)
          : (entering || tick || !en_q) ? OUT_W'(onehot(32'(idx_d), OUT_W))
          : arr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
      arr_q <= '0;
      wrap_q <= 1'b0;
      err_q <= 1'b0;
      en_q <= 1'b1;
    end else begin
      idx_q <= idx_d;
      arr_q <= arr_d;
      wrap_q <= tick && at_last;
      err_q <= accept && !in_range;
      en_q <= bus.en_i;
    end
  end
  assign bus.ready_o = ready;
  assign bus.arr_o = arr_q;
  assign bus.idx_o = idx_q;
  assign bus.wrap_o = wrap_q;
  assign bus.err_o = err_q;
endmodule

// File: tb/tb_dec_onehot_scan.sv
// tb_dec_onehot_scan: directed self-checking bench for an 8-line and a 6-line decoder sharing one stimulus
module tb_dec_onehot_scan;
  logic clk = 1'b0;
  logic rst_n;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  always #5 clk = ~clk;
  dec_onehot_scan_if #(.SEL_W(3), .OUT_W(8), .DWELL_W(4)) b8 ();
  dec_onehot_scan_if #(.SEL_W(3), .OUT_W(6), .DWELL_W(4)) b6 ();
  assign b6.en_i = b8.en_i;
  assign b6.mode_i = b8.mode_i;
  assign b6.sel_i = b8.sel_i;
  assign b6.valid_i = b8.valid_i;
  assign b6.dwell_i = b8.dwell_i;
  dec_onehot_scan #(.SEL_W(3), .OUT_W(8), .DWELL_W(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  dec_onehot_scan #(.SEL_W(3), .OUT_W(6), .DWELL_W(4)) dut6 (.clk(clk), .rst_n(rst_n), .bus(b6));
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    b8.en_i = 1'b1;
    b8.mode_i = 1'b0;
    b8.sel_i = 3'd0;
    b8.valid_i = 1'b0;
    b8.dwell_i = 4'd0;
    step(2);
    chk("rst_arr", b8.arr_o, 8'h00);
    chk("rst_ready", b8.ready_o, 1'b0);
    chk("rst_idx", b8.idx_o, 3'd0);
    chk("rst_err", b8.err_o, 1'b0);
    chk("rst_wrap", b8.wrap_o, 1'b0);
    rst_n = 1'b1;
    b8.valid_i = 1'b1;
    b8.sel_i = 3'd5;
    step(1);
    chk("idle_to_direct_arr", b8.arr_o, 8'h00);
    chk("direct_ready", b8.ready_o, 1'b1);
    step(1);
    chk("dec5_arr", b8.arr_o, 8'h20);
    chk("dec5_idx", b8.idx_o, 3'd5);
    chk("dec5_arr6", b6.arr_o, 8'h20);
    b8.sel_i = 3'd7;
    step(1);
    chk("dec7_arr8", b8.arr_o, 8'h80);
    chk("dec7_idx8", b8.idx_o, 3'd7);
    chk("oor7_arr6", b6.arr_o, 8'h00);
    chk("oor7_idx6", b6.idx_o, 3'd5);
    chk("oor7_err6", b6.err_o, 1'b1);
    chk("dec7_err8", b8.err_o, 1'b0);
    b8.valid_i = 1'b0;
    step(1);
    chk("oor_err_pulse6", b6.err_o, 1'b0);
    chk("oor_hold_arr6", b6.arr_o, 8'h00);
    b8.valid_i = 1'b1;
    b8.sel_i = 3'd6;
    step(1);
    chk("dec6_arr8", b8.arr_o, 8'h40);
    chk("oor6_err6", b6.err_o, 1'b1);
    chk("oor6_idx6", b6.idx_o, 3'd5);
    b8.valid_i = 1'b0;
    b8.sel_i = 3'd2;
    step(1);
    chk("no_valid_hold", b8.arr_o, 8'h40);
    b8.mode_i = 1'b1;
    b8.dwell_i = 4'd2;
    step(1);
    chk("scan_entry_arr", b8.arr_o, 8'h40);
    chk("scan_ready", b8.ready_o, 1'b0);
    step(2);
    chk("scan_dwell_40", b8.arr_o, 8'h40);
    step(1);
    chk("scan_step_80", b8.arr_o, 8'h80);
    chk("scan_idx7", b8.idx_o, 3'd7);
    step(2);
    chk("scan_dwell_80", b8.arr_o, 8'h80);
    chk("scan_nowrap", b8.wrap_o, 1'b0);
    step(1);
    chk("scan_wrap_arr", b8.arr_o, 8'h01);
    chk("scan_wrap_pulse", b8.wrap_o, 1'b1);
    step(1);
    chk("scan_wrap_end", b8.wrap_o, 1'b0);
    b8.en_i = 1'b0;
    step(1);
    chk("blank_arr", b8.arr_o, 8'h00);
    step(3);
    chk("blank_arr4", b8.arr_o, 8'h00);
    chk("blank_idx", b8.idx_o, 3'd1);
    b8.en_i = 1'b1;
    step(1);
    chk("unblank_arr", b8.arr_o, 8'h04);
    chk("unblank_idx", b8.idx_o, 3'd2);
    step(3);
    chk("scan_idx3", b8.idx_o, 3'd3);
    chk("scan_arr08", b8.arr_o, 8'h08);
    b8.mode_i = 1'b0;
    b8.valid_i = 1'b1;
    b8.sel_i = 3'd0;
    step(1);
    chk("leave_hold_arr", b8.arr_o, 8'h08);
    chk("leave_hold_idx", b8.idx_o, 3'd3);
    chk("leave_ready", b8.ready_o, 1'b1);
    step(1);
    chk("post_scan_dec0", b8.arr_o, 8'h01);
    chk("post_scan_idx0", b8.idx_o, 3'd0);
    b8.valid_i = 1'b0;
    b8.mode_i = 1'b1;
    b8.dwell_i = 4'd0;
    step(1);
    chk("dwell0_entry", b8.arr_o, 8'h01);
    step(1);
    chk("dwell0_step1", b8.arr_o, 8'h02);
    step(1);
    chk("dwell0_step2", b8.arr_o, 8'h04);
    chk("dwell0_idx2", b8.idx_o, 3'd2);
    rst_n = 1'b0;
    b8.valid_i = 1'b1;
    b8.sel_i = 3'd7;
    step(1);
    chk("midrst_arr", b8.arr_o, 8'h00);
    chk("midrst_idx", b8.idx_o, 3'd0);
    chk("midrst_wrap", b8.wrap_o, 1'b0);
    chk("midrst_err6", b6.err_o, 1'b0);
    chk("midrst_arr6", b6.arr_o, 8'h00);
    chk("midrst_ready", b8.ready_o, 1'b0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
